// File: rtl/sr_ctrl_pkg.sv
// Shared types and helpers for the SR pulse debouncer: channel state encoding,
// counter sizing and default parameter values.
package sr_ctrl_pkg;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHK_HI  = 2'd1,
      PRESSED = 2'd2,
      CHK_LO  = 2'd3
   } chan_state_e;

   function automatic int cnt_width(input int debounce_cycles);
      return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/sr_pulse_debouncer_if.sv
// Button inputs and latch-side outputs of the SR pulse debouncer.
interface sr_pulse_debouncer_if;

   logic set_btn;
   logic rst_btn;
   logic s_out;
   logic r_out;
   logic set_lvl;
   logic rst_lvl;
   logic conflict;

   modport master (
      output set_btn, rst_btn,
      input  s_out, r_out, set_lvl, rst_lvl, conflict
   );

   modport slave (
      input  set_btn, rst_btn,
      output s_out, r_out, set_lvl, rst_lvl, conflict
   );

endinterface

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, consecutive-sample debounce FSM and press strobe.
// level_nxt and press are combinational so the top can register them without extra latency.
module debounce_chan
   import sr_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level_nxt,
   output logic press
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
   localparam bit             SINGLE   = (DEBOUNCE_CYCLES == 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_s;
   chan_state_e            state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          cnt_inc_s;

   // Synchroniser shift chain next value.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn};
   end

   assign sync_s    = sync_q[SYNC_STAGES-1];
   assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // Debounce FSM: next state, counter and press strobe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_s && SINGLE) begin
               state_d = PRESSED;
               cnt_d   = CNT_ZERO;
               press   = 1'b1;
            end else if (sync_s) begin
               state_d = CHK_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         CHK_HI: begin
            if (!sync_s) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = CNT_ZERO;
               press   = 1'b1;
            end else begin
               cnt_d   = cnt_inc_s;
            end
         end
         PRESSED: begin
            if (!sync_s && SINGLE) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else if (!sync_s) begin
               state_d = CHK_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         CHK_LO: begin
            if (sync_s) begin
               state_d = PRESSED;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_inc_s;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Level is high while pressed or while a release is still being qualified.
   assign level_nxt = (state_d == PRESSED) || (state_d == CHK_LO);

   // Synchroniser, state and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= {SYNC_STAGES{1'b0}};
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/sr_pulse_debouncer.sv
// Two debounced button channels feeding a registered S/R pulse arbiter.
// Build option: define SR_RESET_PRIORITY_EN to let reset win simultaneous presses.
module sr_pulse_debouncer
   import sr_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   sr_pulse_debouncer_if.slave bus
);

   logic ps_s, pr_s, set_lvl_s, rst_lvl_s;
   logic s_out_q, s_out_d;
   logic r_out_q, r_out_d;
   logic conflict_q, conflict_d;
   logic set_lvl_q, set_lvl_d;
   logic rst_lvl_q, rst_lvl_d;

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_set_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (bus.set_btn),
      .level_nxt (set_lvl_s),
      .press     (ps_s)
   );

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_rst_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (bus.rst_btn),
      .level_nxt (rst_lvl_s),
      .press     (pr_s)
   );

   // Arbitration: S and R must never be driven together into the latch.
   always_comb begin
      s_out_d    = ps_s & ~pr_s;
`ifdef SR_RESET_PRIORITY_EN
      r_out_d    = pr_s;
`else
      r_out_d    = pr_s & ~ps_s;
`endif
      conflict_d = ps_s & pr_s;
      set_lvl_d  = set_lvl_s;
      rst_lvl_d  = rst_lvl_s;
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_out_q    <= 1'b0;
         r_out_q    <= 1'b0;
         conflict_q <= 1'b0;
         set_lvl_q  <= 1'b0;
         rst_lvl_q  <= 1'b0;
      end else begin
         s_out_q    <= s_out_d;
         r_out_q    <= r_out_d;
         conflict_q <= conflict_d;
         set_lvl_q  <= set_lvl_d;
         rst_lvl_q  <= rst_lvl_d;
      end
   end

   assign bus.s_out    = s_out_q;
   assign bus.r_out    = r_out_q;
   assign bus.conflict = conflict_q;
   assign bus.set_lvl  = set_lvl_q;
   assign bus.rst_lvl  = rst_lvl_q;

endmodule

// File: tb/tb_sr_pulse_debouncer.sv
// Directed bench for sr_pulse_debouncer at SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Honours SR_RESET_PRIORITY_EN for the simultaneous-press expectations.
module tb_sr_pulse_debouncer;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   s_cnt;
   int   r_cnt;

   sr_pulse_debouncer_if bus ();

   sr_pulse_debouncer #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] outs();
      return {bus.s_out, bus.r_out, bus.set_lvl, bus.rst_lvl, bus.conflict};
   endfunction

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      bus.set_btn = 1'b0;
      bus.rst_btn = 1'b0;

      // Reset state and idle inputs.
      #1;
      chk("reset_outs", 32'(outs()), 32'h0);
      step(); step();
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("idle_outs", 32'(outs()), 32'h0);
      end

      // Clean set press: one pulse after edge 5 (6th edge after the change).
      bus.set_btn = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("press_s_out", 32'(bus.s_out), 32'((k == 6) ? 1 : 0));
         chk("press_set_lvl", 32'(bus.set_lvl), 32'((k >= 6) ? 1 : 0));
         chk("press_r_out", 32'(bus.r_out), 32'h0);
      end
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("hold_outs", 32'(outs()), 32'b00100);
      end

      // Release: same latency to level 0, no strobe.
      bus.set_btn = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("release_set_lvl", 32'(bus.set_lvl), 32'((k < 6) ? 1 : 0));
         chk("release_s_out", 32'(bus.s_out), 32'h0);
      end

      // Bouncing set button never qualifies.
      for (int k = 1; k <= 10; k++) begin
         bus.set_btn = ((k % 2) == 1) ? 1'b1 : 1'b0;
         step();
         chk("bounce_outs", 32'(outs()), 32'h0);
      end
      bus.set_btn = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("bounce_tail_outs", 32'(outs()), 32'h0);
      end

      // Hold set, then press reset: one S pulse then one R pulse, never together.
      s_cnt = 0;
      r_cnt = 0;
      bus.set_btn = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (bus.s_out === 1'b1) s_cnt++;
         chk("seq_s_timing", 32'(bus.s_out), 32'((k == 6) ? 1 : 0));
      end
      bus.rst_btn = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (bus.r_out === 1'b1) r_cnt++;
         chk("seq_r_timing", 32'(bus.r_out), 32'((k == 6) ? 1 : 0));
         chk("seq_never_both", 32'(bus.s_out & bus.r_out), 32'h0);
         chk("seq_no_conflict", 32'(bus.conflict), 32'h0);
      end
      chk("seq_s_count", 32'(s_cnt), 32'd1);
      chk("seq_r_count", 32'(r_cnt), 32'd1);
      chk("seq_levels", 32'({bus.set_lvl, bus.rst_lvl}), 32'b11);
      bus.set_btn = 1'b0;
      bus.rst_btn = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("seq_release_pulses", 32'({bus.s_out, bus.r_out, bus.conflict}), 32'h0);
      end
      chk("seq_release_levels", 32'({bus.set_lvl, bus.rst_lvl}), 32'b00);

      // Simultaneous presses.
      bus.set_btn = 1'b1;
      bus.rst_btn = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("sim_conflict", 32'(bus.conflict), 32'((k == 6) ? 1 : 0));
         chk("sim_s_out", 32'(bus.s_out), 32'h0);
`ifdef SR_RESET_PRIORITY_EN
         chk("sim_r_out", 32'(bus.r_out), 32'((k == 6) ? 1 : 0));
`else
         chk("sim_r_out", 32'(bus.r_out), 32'h0);
`endif
      end
      chk("sim_levels", 32'({bus.set_lvl, bus.rst_lvl}), 32'b11);
      bus.set_btn = 1'b0;
      bus.rst_btn = 1'b0;
      for (int k = 1; k <= 10; k++) step();
      chk("sim_release_outs", 32'(outs()), 32'h0);

      // Reset mid-debounce (counter at 2), then re-debounce after release.
      bus.set_btn = 1'b1;
      for (int k = 1; k <= 4; k++) step();
      chk("mid_before_reset", 32'(outs()), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_in_reset", 32'(outs()), 32'h0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("mid_reset_hold", 32'(outs()), 32'h0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("mid_rearm_s_out", 32'(bus.s_out), 32'((k == 6) ? 1 : 0));
         chk("mid_rearm_set_lvl", 32'(bus.set_lvl), 32'((k >= 6) ? 1 : 0));
      end

      // Reset while level is high clears it at once; held button pulses again.
      rst_n = 1'b0;
      #1;
      chk("lvl_async_clear", 32'(outs()), 32'h0);
      step(); step();
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("lvl_rearm_s_out", 32'(bus.s_out), 32'((k == 6) ? 1 : 0));
         chk("lvl_rearm_set_lvl", 32'(bus.set_lvl), 32'((k >= 6) ? 1 : 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_pulse_debouncer.md
# sr_pulse_debouncer

- Front end for the SR latch stage: it converts two raw, bouncing push-button inputs (set and reset) into clean single-cycle S and R pulses.
- Each button is synchronised, debounced with a consecutive-sample counter, and rising-edge detected.
- The block guarantees that S and R are never asserted together, so the downstream latch never enters its invalid state.
- The debounced levels are also exported for status LEDs.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flops per button (minimum 2).
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to accept a level change (minimum 1).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- set_btn  input  1  raw set button, asynchronous to clk, may bounce.
- rst_btn  input  1  raw reset button, asynchronous to clk, may bounce.
- s_out  output  1  one-cycle set pulse to the latch S input.
- r_out  output  1  one-cycle reset pulse to the latch R input.
- set_lvl  output  1  debounced set-button level.
- rst_lvl  output  1  debounced reset-button level.
- conflict  output  1  one-cycle flag: both buttons were accepted as pressed in the same cycle.

## Operation
- Reset values:
  - All outputs are 0.
  - Synchroniser flops are 0.
  - Counters are 0.
  - Both channel FSMs are in IDLE.
- Channel FSM (one per button), with input sync = synchroniser output:
  - IDLE (level 0): if sync=1, go to CHK_HI with cnt=1; otherwise stay.
  - CHK_HI:
    - If sync=0, return to IDLE with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES-1 (the DEBOUNCE_CYCLES-th consecutive 1), go to PRESSED, set level to 1 and raise the press strobe.
    - Else cnt+1.
    - When DEBOUNCE_CYCLES=1, the first sampled 1 goes directly from IDLE to PRESSED.
  - PRESSED (level 1): if sync=0, go to CHK_LO with cnt=1.
  - CHK_LO: mirror image of CHK_HI; on acceptance, go to IDLE and set level to 0. Release produces no strobe.
- Counter width is clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- Output arbitration on the press strobes ps (set) and pr (reset):
  - ps only: s_out=1.
  - pr only: r_out=1.
  - Both in the same cycle: conflict=1; s_out and r_out are resolved per Configuration.
- A pulse on one channel while the other channel's level is held is legal and is passed through.
- Holding a button produces exactly one pulse. A new pulse requires a debounced release followed by a debounced press.
- Reset mid-operation: everything returns to reset values immediately. A button still held after rst_n deasserts is re-debounced and produces one pulse.

## Timing
- All outputs are registered. s_out, r_out and conflict are high for exactly one clk cycle.
- Press latency: set_btn held stably high from before edge 0 causes s_out=1 and set_lvl=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. With the defaults this is 5 edges.
- Release latency: the same count to set_lvl=0.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no level change and no pulse.
- The two channels are independent; they interact only in arbitration.

## Configuration
- SR_RESET_PRIORITY_EN defined: on simultaneous press strobes, r_out=1 and s_out=0 (reset wins), and conflict=1.
- SR_RESET_PRIORITY_EN undefined: on simultaneous press strobes, s_out=0 and r_out=0 (both dropped), and conflict=1.
- In both builds s_out & r_out is never 1.

## Structure
- Package sr_ctrl_pkg holds:
  - the channel state enum (IDLE, CHK_HI, PRESSED, CHK_LO);
  - a cnt_width function of DEBOUNCE_CYCLES;
  - the SYNC_STAGES and DEBOUNCE_CYCLES default constants.
- Sub-module debounce_chan holds one synchroniser, FSM and counter, and outputs level and press strobe. It is instantiated twice. The top level contains only instances plus arbitration and output registers.

## Test plan
All scenarios use the defaults, SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Reset, then hold all inputs 0 for 20 cycles -> all outputs stay 0.
- set_btn 0->1 held -> s_out=1 exactly once, 5 edges after the change; set_lvl=1 from that edge; r_out stays 0.
- set_btn bounces 1,0,1,0 per cycle for 10 cycles, then stays 0 -> no s_out; set_lvl stays 0.
- Press and hold set_btn, then press rst_btn -> one s_out, then one r_out; they are never high together.
- set_btn and rst_btn rise on the same edge:
  - with SR_RESET_PRIORITY_EN -> r_out=1, s_out=0, conflict=1;
  - without SR_RESET_PRIORITY_EN -> s_out=0, r_out=0, conflict=1.
- Hold set_btn, assert rst_n low mid-debounce (cnt=2), release rst_n -> outputs are 0 during reset; s_out=1 once, 5 edges after release.
